// File: rtl/snake_pkg.sv
// Shared snake types: direction encoding, reversal helper and the reset heading.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    localparam dir_t DIR_RESET = DIR_RIGHT;

    // Opposite heading: the encoding places opposites two apart.
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Button debouncer: 2-flop synchronizer followed by a stability counter.
// A new level is taken once DEBOUNCE_CYCLES consecutive synchronized samples
// disagree with the current level. A rising level produces a one-cycle press.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             press_q;

    // Synchronize, count stable differing samples, commit the level and flag rising edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_q <= sync2_q;
                    press_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/move_scheduler.sv
// Direction command scheduler: debounces the four buttons, picks one press per
// cycle (up > right > down > left), drops duplicates and reversals against the
// most recent queued heading, buffers legal commands and applies one per tick.
module move_scheduler
    import snake_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       up_button,
    input  logic                       right_button,
    input  logic                       down_button,
    input  logic                       left_button,
    input  logic                       tick,
    output logic [1:0]                 direction,
    output logic                       dir_changed,
    output logic [$clog2(DEPTH):0]     queue_count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [3:0] btn_raw;
    logic [3:0] btn_press;
    logic [3:0] btn_level_unused;

    // Index 0 is the highest arbitration priority.
    assign btn_raw = {left_button, down_button, right_button, up_button};

    for (genvar b = 0; b < 4; b++) begin : g_deb
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .btn_in(btn_raw[b]),
            .level (btn_level_unused[b]),
            .press (btn_press[b])
        );
    end

    dir_t          fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    dir_t          dir_q;
    logic          dir_changed_q;
    logic          overflow_q;

    dir_t          cand;
    logic          cand_vld;
    dir_t          ref_dir;
    logic [PW-1:0] tail_idx;
    logic          legal;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    dir_t          dir_d;

    // Arbitrate presses, filter against the pre-pop tail, decide push/pop/drop.
    always_comb begin
        cand_vld = |btn_press;
        cand     = DIR_LEFT;
        if (btn_press[0])      cand = DIR_UP;
        else if (btn_press[1]) cand = DIR_RIGHT;
        else if (btn_press[2]) cand = DIR_DOWN;

        tail_idx = wr_ptr_q - 1'b1;
        ref_dir  = (count_q != '0) ? fifo_q[tail_idx] : dir_q;
        legal    = enable && cand_vld && (cand != ref_dir) && (cand != reverse_dir(ref_dir));

        full = (count_q == FULL_CNT);
        pop  = enable && tick && (count_q != '0);
        push = legal && (!full || pop);
        drop = legal && full && !pop;

        dir_d = dir_q;
        if (!enable)  dir_d = DIR_RESET;
        else if (pop) dir_d = fifo_q[rd_ptr_q];
    end

    // Queue storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (!rst && push) fifo_q[wr_ptr_q] <= cand;
    end

    // Pointers, occupancy, current heading and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            dir_q         <= DIR_RESET;
            dir_changed_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            dir_q         <= dir_d;
            dir_changed_q <= (dir_d != dir_q);
            if (!enable) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                if (push && !pop)      count_q <= count_q + 1'b1;
                else if (pop && !push) count_q <= count_q - 1'b1;
                if (drop) overflow_q <= 1'b1;
            end
        end
    end

    assign direction   = dir_q;
    assign dir_changed = dir_changed_q;
    assign queue_count = count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Scoreboard bench for move_scheduler: expected headings are queued when a tick
// is issued, and a monitor pops one on every dir_changed pulse.
module tb_move_scheduler;

    localparam logic [1:0] UP = 2'd0, RIGHT = 2'd1, DOWN = 2'd2, LEFT = 2'd3;
    // Button masks: {left, down, right, up}
    localparam logic [3:0] M_UP = 4'b0001, M_RIGHT = 4'b0010, M_DOWN = 4'b0100, M_LEFT = 4'b1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       up_button = 1'b0, right_button = 1'b0, down_button = 1'b0, left_button = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] direction;
    logic       dir_changed;
    logic [2:0] queue_count;
    logic       overflow;

    int checks   = 0;
    int failures = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    move_scheduler #(
        .DEPTH          (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .up_button   (up_button),
        .right_button(right_button),
        .down_button (down_button),
        .left_button (left_button),
        .tick        (tick),
        .direction   (direction),
        .dir_changed (dir_changed),
        .queue_count (queue_count),
        .overflow    (overflow)
    );

    // Monitor: every dir_changed pulse must match the next expected heading.
    always @(negedge clk) begin : monitor
        logic [1:0] e;
        if (dir_changed === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL dir_changed_unexpected actual_dir=%0d required=no_pulse", direction);
            end else begin
                e = exp_q.pop_front();
                if (direction !== e) begin
                    failures++;
                    $display("FAIL dir_on_change actual=%0d required=%0d", direction, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_direction"}, 32'(direction), 32'(RIGHT));
        chk({tag, "_dir_changed"}, 32'(dir_changed), 0);
        chk({tag, "_queue_count"}, 32'(queue_count), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk_reset_state(tag);
        rst = 1'b0;
    endtask

    // Hold buttons long enough to debounce; the press event reaches the
    // queue at the 7th rising edge after the buttons go high, which is
    // where the optional tick is aligned.
    task automatic do_press(input logic [3:0] m, input bit with_tick);
        @(negedge clk);
        {left_button, down_button, right_button, up_button} = m;
        repeat (6) @(negedge clk);
        tick = with_tick;
        @(negedge clk);
        tick = 1'b0;
        {left_button, down_button, right_button, up_button} = 4'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_tick(input string name, input logic [1:0] exp_dir, input bit changes);
        if (changes) exp_q.push_back(exp_dir);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        chk(name, 32'(direction), 32'(exp_dir));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        do_reset("reset");

        // Debounce: a 3-cycle glitch is ignored, a long hold gives one push
        @(negedge clk); down_button = 1'b1;
        repeat (3) @(negedge clk);
        down_button = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_qc", 32'(queue_count), 0);
        @(negedge clk); down_button = 1'b1;
        repeat (10) @(negedge clk);
        down_button = 1'b0;
        repeat (10) @(negedge clk);
        chk("hold_qc", 32'(queue_count), 1);
        do_tick("hold_tick_dir", DOWN, 1'b1);

        // Simultaneous up+left queues only UP; DOWN then is a reversal
        do_reset("reset2");
        do_press(M_UP | M_LEFT, 1'b0);
        chk("arb_qc", 32'(queue_count), 1);
        do_press(M_DOWN, 1'b0);
        chk("reversal_qc", 32'(queue_count), 1);
        do_tick("arb_tick_dir", UP, 1'b1);
        chk("arb_after_qc", 32'(queue_count), 0);

        // Overflow, drain order, empty tick, enable drop
        do_reset("reset3");
        do_press(M_UP, 1'b0);
        do_press(M_LEFT, 1'b0);
        do_press(M_DOWN, 1'b0);
        do_press(M_RIGHT, 1'b0);
        chk("fill_qc", 32'(queue_count), 4);
        chk("fill_ovf", 32'(overflow), 0);
        do_press(M_UP, 1'b0);
        chk("ovf_qc", 32'(queue_count), 4);
        chk("ovf_flag", 32'(overflow), 1);
        do_tick("drain1", UP, 1'b1);
        do_tick("drain2", LEFT, 1'b1);
        do_tick("drain3", DOWN, 1'b1);
        do_tick("drain4", RIGHT, 1'b1);
        chk("drain_qc", 32'(queue_count), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        do_tick("empty_tick_dir", RIGHT, 1'b0);
        do_press(M_UP, 1'b0);
        do_press(M_LEFT, 1'b0);
        chk("pre_disable_qc", 32'(queue_count), 2);
        @(negedge clk); enable = 1'b0;
        @(negedge clk);
        chk("disable_qc", 32'(queue_count), 0);
        chk("disable_dir", 32'(direction), 32'(RIGHT));
        chk("disable_ovf", 32'(overflow), 0);
        enable = 1'b1;
        do_press(M_UP, 1'b0);
        chk("reenable_qc", 32'(queue_count), 1);

        // Push and pop in the same cycle while full
        do_reset("reset4");
        do_press(M_UP, 1'b0);
        do_press(M_LEFT, 1'b0);
        do_press(M_DOWN, 1'b0);
        do_press(M_RIGHT, 1'b0);
        exp_q.push_back(UP);
        do_press(M_UP, 1'b1);
        chk("pushpop_dir", 32'(direction), 32'(UP));
        chk("pushpop_qc", 32'(queue_count), 4);
        chk("pushpop_ovf", 32'(overflow), 0);
        do_tick("pp_drain1", LEFT, 1'b1);
        do_tick("pp_drain2", DOWN, 1'b1);
        do_tick("pp_drain3", RIGHT, 1'b1);
        do_tick("pp_drain4", UP, 1'b1);
        chk("pp_drain_qc", 32'(queue_count), 0);

        // Reset mid-burst with a tick in the same cycle
        do_press(M_LEFT, 1'b0);
        do_press(M_DOWN, 1'b0);
        chk("burst_qc", 32'(queue_count), 2);
        @(negedge clk); rst = 1'b1; tick = 1'b1;
        @(negedge clk);
        chk_reset_state("midreset");
        rst = 1'b0; tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset_hold_dir", 32'(direction), 32'(RIGHT));

        chk("scoreboard_leftover", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/move_scheduler.md
# move_scheduler

Sequences player direction commands for the snake. It debounces the four direction buttons, arbitrates simultaneous presses, and rejects illegal commands (duplicates, 180° reversals). Accepted commands are buffered in a small FIFO and one is released on each movement tick. It sits between the raw button inputs and `snake_controller`, clocked by the system `clk`; the movement tick comes from the movement timer.

## Interface
- `DEPTH`, 4: direction FIFO depth, power of two, ≥2.
- `DEBOUNCE_CYCLES`, 500000: cycles a synchronized button level must be stable before it is accepted.
- `clk` input 1: system clock; the only clock.
- `rst` input 1: reset, synchronous, active-high.
- `enable` input 1: high while the game FSM is in PLAYING.
- `up_button`, `right_button`, `down_button`, `left_button` input 1 each: raw, asynchronous, active-high.
- `tick` input 1: one-`clk` pulse per snake step, synchronous to `clk`.
- `direction` output 2: current movement direction; UP=0, RIGHT=1, DOWN=2, LEFT=3.
- `dir_changed` output 1: one-cycle pulse when `direction` changes value.
- `queue_count` output $clog2(DEPTH)+1: number of buffered commands.
- `overflow` output 1: sticky; a legal command was dropped because the FIFO was full.

## Operation
- **Per-button debounce**
  - 2-flop synchronizer, then a stability counter.
  - The debounced level updates only after DEBOUNCE_CYCLES consecutive equal samples.
  - A rising edge of the debounced level produces a one-cycle press event.
  - Falling edges produce no event.
- **Arbitration**
  - If several press events occur in the same cycle, only the highest priority is considered: up > right > down > left.
  - The other press events are discarded, not deferred.
- **Filter**
  - Reference direction = FIFO tail if the FIFO is non-empty, else `direction`.
  - A candidate is rejected if it equals the reference.
  - A candidate is rejected if it equals the reference XOR 2 (reversal).
  - Rejection is silent.
- **Push**
  - A legal candidate is written at the tail.
  - If the FIFO is full, the candidate is dropped and `overflow` is set.
- **Pop**
  - On `tick` with a non-empty FIFO: `direction` ← head, then the head is popped.
  - On `tick` with an empty FIFO: `direction` holds.
  - There is no bypass: a command pushed in the same cycle as `tick` on an empty FIFO is applied on the next `tick`.
- **Simultaneous push and pop**
  - Both occur; `queue_count` is unchanged.
  - The filter uses the pre-pop tail.
  - A push when full coinciding with a pop is accepted (the slot frees this cycle).
- **enable low**
  - FIFO is flushed, `direction` ← RIGHT, `overflow` cleared.
  - Press events and ticks are ignored.
  - Debouncers keep running, so a button held through the `enable` rise does not generate an event.
- **Reset values**
  - `direction`=RIGHT, `dir_changed`=0, `queue_count`=0, `overflow`=0.
  - FIFO pointers and all debounced levels = 0.
  - Synchronizers and counters = 0.

## Timing
- **Button to press event:** 2 sync cycles + DEBOUNCE_CYCLES.
- **Press event to queue:** press event at cycle N → `queue_count` reflects the push at N+1.
- **Tick to direction:** `tick` at cycle T → `direction` valid at T+1, `dir_changed` high during T+1 only.
- **Output registering:** all outputs are registered; no combinational paths from inputs to outputs.
- **Reset mid-operation:** reset takes priority over `enable`, `tick` and pushes in the same cycle; outputs hold reset values on the cycle after `rst` is sampled high.
- **Pointer wrap:** pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty is decided by `queue_count`, never by pointer equality alone.

## Structure
- **Shared package `snake_pkg`:**
  - `dir_t` (2-bit enum DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT).
  - Function `reverse_dir` (XOR 2).
  - Constant `DIR_RESET`=DIR_RIGHT.
  - `snake_controller` imports the same package.
- **Sub-module `button_debouncer`** (parameter DEBOUNCE_CYCLES; ports `clk`, `rst`, `btn_in`, `level`, `press`): instantiated four times.
- **Kept in `move_scheduler`:** arbitration, filter and FIFO stay inline in one module.

## Test plan
DEBOUNCE_CYCLES=4 for simulation.
- **Debounce:** after reset with `enable`=1, pulse `down_button` for 3 cycles → no push, `queue_count`=0. Hold it for 10 cycles → exactly one push, `queue_count`=1.
- **Simultaneous press and reversal:** press up and left in the same cycle → only UP is queued. Then press down → rejected (reversal of the tail UP), `queue_count` stays 1.
- **Overflow:** with DEPTH=4, queue UP, LEFT, DOWN, RIGHT (no ticks) → `queue_count`=4. Press up → dropped, `overflow`=1. Then 4 ticks → `direction` sequence UP, LEFT, DOWN, RIGHT, with a `dir_changed` pulse on each.
- **Push/pop same cycle:** with `queue_count`=4, fire a legal press and `tick` in the same cycle → push accepted, `queue_count` stays 4, `overflow` stays 0.
- **Tick on empty FIFO and enable drop:** `tick` with an empty FIFO → `direction` unchanged, no `dir_changed`. Drop `enable` with 2 queued commands → `queue_count`=0, `direction`=RIGHT, `overflow`=0 next cycle.
- **Reset mid-burst:** assert `rst` for one cycle while commands are queued and `tick` is high → all outputs at reset values the following cycle.
